systolic_pe_acc: RTL and testbench



---
 rtl/systolic_pkg.sv | 35 +++
 rtl/pe_requant.sv | 22 ++
 rtl/systolic_pe_acc.sv | 128 ++++++++++++
 tb/tb_systolic_pe_acc.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types, width checks and the requantisation function for the systolic PE.
package systolic_pkg;

  // Internal width used by the requant arithmetic; wide enough that the
  // rounding add and the clamp never wrap for any legal accumulator width.
  localparam int unsigned MaxW = 128;

  typedef enum logic [0:0] {RUN, PASS} pe_state_e;

  // Legal parameter combinations for a PE instance.
  function automatic bit widths_ok(input int unsigned dw, input int unsigned aw,
                                   input int unsigned fb);
    return (dw >= 2) && (aw >= 2 * dw) && (aw <= MaxW - 2) && (fb <= aw - dw);
  endfunction

  // Round half-up, arithmetic shift, saturate to dw bits, then optional ReLU.
  function automatic logic signed [MaxW-1:0] requant(input logic signed [MaxW-1:0] s,
                                                     input int unsigned frac,
                                                     input int unsigned dw,
                                                     input logic relu);
    logic signed [MaxW-1:0] r;
    logic signed [MaxW-1:0] hi;
    logic signed [MaxW-1:0] lo;
    r = s;
    if (frac > 0) r = r + (MaxW'(1) << (frac - 1));
    r  = r >>> frac;
    hi = (MaxW'(1) << (dw - 1)) - MaxW'(1);
    lo = -hi - MaxW'(1);
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    if (relu && r[MaxW-1]) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/pe_requant.sv
// Combinational requantisation of the accumulator down to the result width.
module pe_requant
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic signed [ACC_WIDTH-1:0]  i_acc,
  input  logic                         i_relu,
  output logic signed [DATA_WIDTH-1:0] o_q
);

  logic signed [MaxW-1:0] w_ext;

  // Sign-extend into the wide domain, then round/shift/saturate/ReLU.
  always_comb begin
    w_ext = MaxW'(i_acc);
    o_q   = DATA_WIDTH'(requant(w_ext, FRAC_BITS, DATA_WIDTH, i_relu));
  end

endmodule

// File: rtl/systolic_pe_acc.sv
// Output-stationary systolic PE: gated MAC into a wide accumulator, operand
// forwarding, requantised snapshot on drain, and a counted pass-through chain.
module systolic_pe_acc
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned CHAIN_POS  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_in,
  input  logic                         drain_in,
  input  logic                         relu_en,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic                         a_valid_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  input  logic                         b_valid_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic                         a_valid_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic                         b_valid_out,
  input  logic signed [DATA_WIDTH-1:0] psum_in,
  input  logic                         psum_valid_in,
  output logic signed [DATA_WIDTH-1:0] psum_out,
  output logic                         psum_valid_out,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned CntW = (CHAIN_POS > 0) ? $clog2(CHAIN_POS + 1) : 1;

  if (!widths_ok(DATA_WIDTH, ACC_WIDTH, FRAC_BITS)) begin : g_bad_widths
    $error("systolic_pe_acc: illegal DATA_WIDTH/ACC_WIDTH/FRAC_BITS combination");
  end

  pe_state_e                        r_state;
  logic        [CntW-1:0]           r_cnt;
  logic signed [ACC_WIDTH-1:0]      r_acc;
  logic signed [2*DATA_WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0]      w_acc_next;
  logic signed [DATA_WIDTH-1:0]     w_snap;
  logic                             w_drain_ok;

  // Gated product and next accumulator value (wraps at ACC_WIDTH).
  always_comb begin
    w_prod     = a_in * b_in;
    w_acc_next = r_acc;
    if (a_valid_in && b_valid_in) w_acc_next = r_acc + ACC_WIDTH'(w_prod);
    w_drain_ok = drain_in && (r_state == RUN);
  end

  pe_requant #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_requant (
    .i_acc  (w_acc_next),
    .i_relu (relu_en),
    .o_q    (w_snap)
  );

  // Unconditional one-cycle operand forwarding to the neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  // Accumulator: accepted drain or clear restarts from zero, otherwise accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_drain_ok || clear_in) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

  // Drain FSM: emit own snapshot, then forward CHAIN_POS valid upstream words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (drain_in) begin
            psum_out       <= w_snap;
            psum_valid_out <= 1'b1;
            if (CHAIN_POS != 0) begin
              r_state <= PASS;
              r_cnt   <= CntW'(CHAIN_POS);
            end
          end else begin
            psum_valid_out <= 1'b0;
          end
        end
        PASS: begin
          psum_out       <= psum_in;
          psum_valid_out <= psum_valid_in;
          if (drain_in) overrun <= 1'b1;
          if (psum_valid_in) begin
            r_cnt <= r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign busy = (r_state == PASS);

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Randomised self-checking bench for systolic_pe_acc (CHAIN_POS=2) against a
// behavioural model, plus directed literal checks from the test plan.
module tb_systolic_pe_acc;

  localparam int unsigned Dw = 16;
  localparam int unsigned Cp = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear_in, drain_in, relu_en;
  logic signed [Dw-1:0] a_in, b_in, psum_in;
  logic                 a_valid_in, b_valid_in, psum_valid_in;
  logic signed [Dw-1:0] a_out, b_out, psum_out;
  logic                 a_valid_out, b_valid_out, psum_valid_out, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state
  longint               m_acc;
  int                   m_rem;
  bit                   m_over;
  logic signed [Dw-1:0] m_psum, m_a, m_b;
  bit                   m_pv, m_av, m_bv;

  systolic_pe_acc #(
    .DATA_WIDTH (Dw),
    .ACC_WIDTH  (40),
    .FRAC_BITS  (8),
    .CHAIN_POS  (Cp)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear_in       (clear_in),
    .drain_in       (drain_in),
    .relu_en        (relu_en),
    .a_in           (a_in),
    .a_valid_in     (a_valid_in),
    .b_in           (b_in),
    .b_valid_in     (b_valid_in),
    .a_out          (a_out),
    .a_valid_out    (a_valid_out),
    .b_out          (b_out),
    .b_valid_out    (b_valid_out),
    .psum_in        (psum_in),
    .psum_valid_in  (psum_valid_in),
    .psum_out       (psum_out),
    .psum_valid_out (psum_valid_out),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap40(input longint x);
    return (x <<< 24) >>> 24;
  endfunction

  function automatic logic signed [Dw-1:0] m_requant(input longint s, input bit relu);
    longint r;
    r = (s + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_rem = 0; m_over = 0;
    m_psum = '0; m_pv = 0; m_a = '0; m_b = '0; m_av = 0; m_bv = 0;
  endfunction

  // One clock of the behavioural model, from the inputs present at the edge.
  function automatic void model_step();
    longint accn;
    accn = m_acc;
    if (a_valid_in && b_valid_in) accn = wrap40(m_acc + longint'(a_in) * longint'(b_in));
    m_a = a_in; m_av = a_valid_in; m_b = b_in; m_bv = b_valid_in;
    if (m_rem == 0 && drain_in) begin
      m_psum = m_requant(accn, relu_en);
      m_pv   = 1;
      m_rem  = Cp;
      m_acc  = 0;
    end else begin
      if (m_rem > 0) begin
        m_psum = psum_in;
        m_pv   = psum_valid_in;
        if (psum_valid_in) m_rem--;
        if (drain_in) m_over = 1;
      end else begin
        m_pv = 0;
      end
      m_acc = clear_in ? 0 : accn;
    end
  endfunction

  // Compare process: model advances on each edge, DUT sampled 1 time unit later.
  always @(posedge clk) begin
    if (!rst) model_step();
    #1;
    if (chk_en) begin
      check("a_out", a_out, m_a);
      check("a_valid_out", 16'(a_valid_out), 16'(m_av));
      check("b_out", b_out, m_b);
      check("b_valid_out", 16'(b_valid_out), 16'(m_bv));
      check("psum_valid_out", 16'(psum_valid_out), 16'(m_pv));
      if (m_pv) check("psum_out", psum_out, m_psum);
      check("busy", 16'(busy), 16'(m_rem > 0));
      check("overrun", 16'(overrun), 16'(m_over));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mac(input logic [15:0] a, input logic [15:0] b, input bit av, input bit bv);
    a_in = a; b_in = b; a_valid_in = av; b_valid_in = bv;
    tick();
    a_valid_in = 0; b_valid_in = 0;
  endtask

  task automatic drain_check(input string name, input logic [15:0] exp);
    a_valid_in = 0; b_valid_in = 0; drain_in = 1;
    tick();
    drain_in = 0;
    check(name, psum_out, exp);
    check({name, "_valid"}, 16'(psum_valid_out), 16'h1);
  endtask

  task automatic flush();
    for (int i = 0; i < Cp; i++) begin
      psum_in = 16'($urandom); psum_valid_in = 1;
      tick();
    end
    psum_valid_in = 0;
    check("flush_busy", 16'(busy), 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clear_in = 0; drain_in = 0; relu_en = 0;
    a_in = '0; b_in = '0; a_valid_in = 0; b_valid_in = 0;
    psum_in = '0; psum_valid_in = 0;
    model_reset();
    chk_en = 1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_psum_out", psum_out, 16'h0);
    check("rst_psum_valid", 16'(psum_valid_out), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    check("rst_a_out", a_out, 16'h0);
    rst = 0;
    tick();

    // Basic MAC
    repeat (3) mac(16'h0100, 16'h0200, 1, 1);
    drain_check("basic_mac", 16'h0600);
    check("basic_busy", 16'(busy), 16'h1);
    tick();
    check("basic_pulse_end", 16'(psum_valid_out), 16'h0);
    flush();

    // Valid gating
    mac(16'h0100, 16'h0200, 1, 1);
    mac(16'h0100, 16'h0200, 0, 1);
    mac(16'h0100, 16'h0200, 1, 1);
    drain_check("gating", 16'h0400);
    flush();

    // Saturation
    repeat (4) mac(16'h7FFF, 16'h7FFF, 1, 1);
    drain_check("sat_pos", 16'h7FFF);
    flush();
    repeat (4) mac(16'h8000, 16'h7FFF, 1, 1);
    drain_check("sat_neg", 16'h8000);
    flush();

    // Rounding and ReLU
    mac(16'h0180, 16'h0001, 1, 1);
    drain_check("round_pos", 16'h0002);
    flush();
    mac(16'hFE80, 16'h0001, 1, 1);
    drain_check("round_neg", 16'hFFFF);
    flush();
    relu_en = 1;
    mac(16'hFE80, 16'h0001, 1, 1);
    drain_check("relu_neg", 16'h0000);
    relu_en = 0;
    flush();

    // Chain with a bubble; product during PASS lands in next snapshot
    mac(16'h0100, 16'h0300, 1, 1);
    drain_check("chain_own", 16'h0300);
    psum_in = 16'h0011; psum_valid_in = 1;
    a_in = 16'h0100; b_in = 16'h0100; a_valid_in = 1; b_valid_in = 1;
    tick();
    a_valid_in = 0; b_valid_in = 0;
    check("chain_w1", psum_out, 16'h0011);
    check("chain_w1_valid", 16'(psum_valid_out), 16'h1);
    check("chain_w1_busy", 16'(busy), 16'h1);
    psum_valid_in = 0;
    tick();
    check("chain_bubble_valid", 16'(psum_valid_out), 16'h0);
    check("chain_bubble_busy", 16'(busy), 16'h1);
    psum_in = 16'h0022; psum_valid_in = 1;
    tick();
    psum_valid_in = 0;
    check("chain_w2", psum_out, 16'h0022);
    check("chain_w2_valid", 16'(psum_valid_out), 16'h1);
    check("chain_done_busy", 16'(busy), 16'h0);
    drain_check("pass_product", 16'h0100);
    flush();

    // Drain during PASS: overrun, accumulator untouched
    mac(16'h0100, 16'h0100, 1, 1);
    drain_check("ovr_first", 16'h0100);
    mac(16'h0200, 16'h0100, 1, 1);
    drain_in = 1;
    tick();
    drain_in = 0;
    check("ovr_flag", 16'(overrun), 16'h1);
    check("ovr_busy", 16'(busy), 16'h1);
    flush();
    drain_check("ovr_acc_kept", 16'h0200);
    flush();
    check("ovr_sticky", 16'(overrun), 16'h1);

    // Asynchronous reset in the middle of PASS
    mac(16'h0100, 16'h0100, 1, 1);
    a_in = 16'h1234; a_valid_in = 1; drain_in = 1;
    tick();
    drain_in = 0;
    check("arst_pre_busy", 16'(busy), 16'h1);
    check("arst_pre_psum", psum_out, 16'h0100);
    @(negedge clk);
    #1;
    rst = 1;
    model_reset();
    #1;
    check("arst_psum_out", psum_out, 16'h0);
    check("arst_psum_valid", 16'(psum_valid_out), 16'h0);
    check("arst_busy", 16'(busy), 16'h0);
    check("arst_overrun", 16'(overrun), 16'h0);
    check("arst_a_out", a_out, 16'h0);
    tick();
    rst = 0;
    a_valid_in = 0;
    tick();

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a_in = 16'($urandom); b_in = 16'($urandom);
      end else begin
        a_in = 16'($signed($urandom_range(0, 1023)) - 512);
        b_in = 16'($signed($urandom_range(0, 1023)) - 512);
      end
      a_valid_in    = ($urandom_range(0, 3) != 0);
      b_valid_in    = ($urandom_range(0, 3) != 0);
      drain_in      = ($urandom_range(0, 11) == 0);
      clear_in      = ($urandom_range(0, 15) == 0);
      relu_en       = $urandom_range(0, 1) == 1;
      psum_in       = 16'($urandom);
      psum_valid_in = $urandom_range(0, 1) == 1;
      tick();
    end
    drain_in = 0; clear_in = 0; psum_valid_in = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
